pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_slot.sv | 28 ++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for the pipeline stage register.
// The block parameters of the same names take their defaults from here.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One load-enabled, clearable {data,ctrl} storage entry.
// A clear always takes priority over a load.
module pipe_slot #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional skid entry so in_ready can be a flop.
// Handshake: a word moves on an edge where valid && ready; valid never waits on ready.
module pipe_stage_reg #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_pkg::*;

  localparam int SLOT_W = DATA_W + CTRL_W;

  pipe_state_e       r_state;
  pipe_state_e       w_next;
  logic              w_accept;
  logic              w_release;
  logic              w_main_load;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic [SLOT_W-1:0] w_in_word;
  logic [SLOT_W-1:0] w_main_d;
  logic [SLOT_W-1:0] w_main_q;
  logic [SLOT_W-1:0] w_skid_q;
  logic [CNT_W-1:0]  r_stall;

  assign w_in_word = {in_data, in_ctrl};
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  always_comb begin
    w_next      = r_state;
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    w_main_d    = w_in_word;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next      = ST_ONE;
          w_main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_release) begin
          w_main_load = 1'b1;
        end else if (w_accept) begin
          w_next      = ST_FULL;
          w_skid_load = 1'b1;
        end else if (w_release) begin
          w_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // The skid entry is always the older of any new arrival, so it moves up first.
        if (w_release) begin
          w_next      = ST_ONE;
          w_main_load = 1'b1;
          w_main_d    = w_skid_q;
          w_skid_clr  = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
    if (flush) begin
      w_next = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk    (CLK),
    .rst_n  (reset_n),
    .i_clr  (flush),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_ready;

      // Ready is computed from the next state so it never depends on out_ready this cycle.
      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
          r_ready <= 1'b0;
        end else begin
          r_ready <= (w_next != ST_FULL);
        end
      end

      assign in_ready = r_ready;

      pipe_slot #(.W(SLOT_W)) u_skid (
        .clk    (CLK),
        .rst_n  (reset_n),
        .i_clr  (flush || w_skid_clr),
        .i_load (w_skid_load),
        .i_d    (w_in_word),
        .o_q    (w_skid_q)
      );
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
      assign w_skid_q = '0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  // Bubbles present as all-zero so no stale write enable leaks downstream.
  assign {out_data, out_ctrl} = out_valid ? w_main_q : '0;
  assign stall_cnt            = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, pass-through and 3-bit-counter instances.
// Each task drives one scenario and checks its own hand-computed expectations.
module tb_pipe_stage_reg;

  logic        CLK;
  logic        reset_n;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_ctrl;
  logic        flush;
  logic [15:0] stall_cnt;

  logic        c3_in_ready;
  logic        c3_out_valid;
  logic [31:0] c3_out_data;
  logic [3:0]  c3_out_ctrl;
  logic [2:0]  c3_stall_cnt;

  logic        z_in_valid;
  logic        z_in_ready;
  logic [31:0] z_in_data;
  logic [3:0]  z_in_ctrl;
  logic        z_out_valid;
  logic        z_out_ready;
  logic [31:0] z_out_data;
  logic [3:0]  z_out_ctrl;
  logic        z_flush;
  logic [15:0] z_stall_cnt;

  int n_cmp;
  int n_err;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(16)) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(3)) dut_c3 (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (c3_in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (c3_out_valid),
    .out_ready (out_ready),
    .out_data  (c3_out_data),
    .out_ctrl  (c3_out_ctrl),
    .flush     (flush),
    .stall_cnt (c3_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(0), .CNT_W(16)) dut_z (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .in_data   (z_in_data),
    .in_ctrl   (z_in_ctrl),
    .out_valid (z_out_valid),
    .out_ready (z_out_ready),
    .out_data  (z_out_data),
    .out_ctrl  (z_out_ctrl),
    .flush     (z_flush),
    .stall_cnt (z_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid    = 1'b0;
    in_data     = '0;
    in_ctrl     = '0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    z_in_valid  = 1'b0;
    z_in_data   = '0;
    z_in_ctrl   = '0;
    z_out_ready = 1'b0;
    z_flush     = 1'b0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    idle_inputs();
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_ctrl !== 4'h0) begin n_err++; $display("FAIL rst_out_ctrl: got %h want 0", out_ctrl); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (z_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_z_out_valid: got %b want 0", z_out_valid); end
    step();
    step();
    reset_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_ready: got %b want 1", in_ready); end
    n_cmp++; if (c3_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_c3_ready: got %b want 1", c3_in_ready); end
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_ctrl   = 4'b1001;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h1234_5678) begin n_err++; $display("FAIL single_data: got %h want 12345678", out_data); end
    n_cmp++; if (out_ctrl !== 4'b1001) begin n_err++; $display("FAIL single_ctrl: got %b want 1001", out_ctrl); end
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_bubble_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL single_bubble_data: got %h want 0", out_data); end
    n_cmp++; if (out_ctrl !== 4'h0) begin n_err++; $display("FAIL single_bubble_ctrl: got %h want 0", out_ctrl); end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    in_ctrl   = 4'h1;
    step();
    n_cmp++; if (out_data !== 32'hA) begin n_err++; $display("FAIL bp_a_data: got %h want a", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_a_ready: got %b want 1", in_ready); end
    in_data = 32'hB;
    in_ctrl = 4'h2;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL bp_stall1: got %0d want 1", stall_cnt); end
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (out_data !== 32'hA || out_ctrl !== 4'h1) begin n_err++; $display("FAIL bp_hold_%0d: got %h/%h want a/1", i, out_data, out_ctrl); end
    end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL bp_stall5: got %0d want 5", stall_cnt); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_comb_ready: got %b want 0", in_ready); end
    step();
    n_cmp++; if (out_data !== 32'hB || out_ctrl !== 4'h2) begin n_err++; $display("FAIL bp_b_out: got %h/%h want b/2", out_data, out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL bp_stall_kept: got %0d want 5", stall_cnt); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_err++; $display("FAIL bp_drained: got %b/%h want 0/0", out_valid, out_data); end
  endtask

  task automatic test_passthru;
    do_reset();
    z_out_ready = 1'b0;
    z_in_valid  = 1'b1;
    z_in_data   = 32'h55;
    z_in_ctrl   = 4'h6;
    #1;
    n_cmp++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL pt_empty_ready: got %b want 1", z_in_ready); end
    step();
    n_cmp++; if (z_out_valid !== 1'b1 || z_out_data !== 32'h55) begin n_err++; $display("FAIL pt_first: got %b/%h want 1/55", z_out_valid, z_out_data); end
    n_cmp++; if (z_in_ready !== 1'b0) begin n_err++; $display("FAIL pt_blocked: got %b want 0", z_in_ready); end
    z_out_ready = 1'b1;
    z_in_data   = 32'h66;
    z_in_ctrl   = 4'h7;
    #1;
    n_cmp++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL pt_comb_ready: got %b want 1", z_in_ready); end
    step();
    n_cmp++; if (z_out_data !== 32'h66 || z_out_ctrl !== 4'h7) begin n_err++; $display("FAIL pt_second: got %h/%h want 66/7", z_out_data, z_out_ctrl); end
    z_in_valid = 1'b0;
    step();
    n_cmp++; if (z_out_valid !== 1'b0 || z_out_data !== 32'h0) begin n_err++; $display("FAIL pt_bubble: got %b/%h want 0/0", z_out_valid, z_out_data); end
  endtask

  task automatic test_streaming(input bit use_z);
    logic [31:0] exp_q[$];
    logic [31:0] want;
    logic [31:0] rdata;
    logic [3:0]  rctrl;
    bit          acc;
    bit          rel;
    bit          rdy;
    int          sent;
    int          got;
    int          cyc;
    do_reset();
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((got < 100) && (cyc < 3000)) begin
      rdy = 1'($urandom_range(0, 1));
      if (use_z) begin
        z_out_ready = rdy;
        z_in_valid  = (sent < 100);
        z_in_data   = 32'(sent);
        z_in_ctrl   = 4'(sent);
      end else begin
        out_ready = rdy;
        in_valid  = (sent < 100);
        in_data   = 32'(sent);
        in_ctrl   = 4'(sent);
      end
      #1;
      acc   = use_z ? (z_in_valid && z_in_ready) : (in_valid && in_ready);
      rel   = use_z ? (z_out_valid && z_out_ready) : (out_valid && out_ready);
      rdata = use_z ? z_out_data : out_data;
      rctrl = use_z ? z_out_ctrl : out_ctrl;
      step();
      cyc++;
      if (rel) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream%0d_extra: got %h want nothing", use_z, rdata);
        end else begin
          want = exp_q.pop_front();
          if (rdata !== want || rctrl !== want[3:0]) begin
            n_err++; $display("FAIL stream%0d_word: got %h/%h want %h/%h", use_z, rdata, rctrl, want, want[3:0]);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(32'(sent));
        sent++;
      end
    end
    idle_inputs();
    n_cmp++; if (got != 100) begin n_err++; $display("FAIL stream%0d_count: got %0d want 100", use_z, got); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream%0d_leftover: got %0d want 0", use_z, exp_q.size()); end
  endtask

  task automatic test_flush;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    in_ctrl   = 4'h3;
    step();
    in_data = 32'h2;
    in_ctrl = 4'h5;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_full: got %b want 0", in_ready); end
    in_data   = 32'hC;
    in_ctrl   = 4'hF;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 4'h0 || out_data !== 32'h0) begin n_err++; $display("FAIL fl_zero: got %h/%h want 0/0", out_data, out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready: got %b want 1", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL fl_stall_kept: got %0d want 1", stall_cnt); end
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_emit_%0d: got %b/%h want 0", i, out_valid, out_data); end
    end
    // Flush must also beat an accept that would otherwise land in an empty stage.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD;
    in_ctrl   = 4'h4;
    flush     = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin n_err++; $display("FAIL fl_accept_kill: got %b/%h want 0/0", out_valid, out_ctrl); end
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_accept_late: got %b want 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_stall_sat;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h7;
    in_ctrl   = 4'h1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    n_cmp++; if (c3_stall_cnt !== 3'd6) begin n_err++; $display("FAIL sat_six: got %0d want 6", c3_stall_cnt); end
    step();
    n_cmp++; if (c3_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_seven: got %0d want 7", c3_stall_cnt); end
    repeat (3) step();
    n_cmp++; if (c3_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_hold: got %0d want 7", c3_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd10) begin n_err++; $display("FAIL sat_wide: got %0d want 10", stall_cnt); end
    repeat (3) step();
    n_cmp++; if (c3_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_hold2: got %0d want 7", c3_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd13) begin n_err++; $display("FAIL sat_wide2: got %0d want 13", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_async_reset;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hE1;
    in_ctrl   = 4'h1;
    step();
    in_data = 32'hE2;
    in_ctrl = 4'h2;
    step();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ar_full: got %b want 0", in_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ctrl !== 4'h0) begin n_err++; $display("FAIL ar_outputs: got %b/%h/%h want 0/0/0", out_valid, out_data, out_ctrl); end
    n_cmp++; if (in_ready !== 1'b0 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL ar_ready_stall: got %b/%0d want 0/0", in_ready, stall_cnt); end
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready_back: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_no_emit_%0d: got %b/%h want 0", i, out_valid, out_data); end
      step();
    end
    idle_inputs();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_passthru();
    test_streaming(1'b0);
    test_streaming(1'b1);
    test_flush();
    test_stall_sat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
